// File: rtl/sqtri_pkg.sv
// Shared constants, source-select enum and a 16-bit leading-zero helper
// for the square/triangle wavetable generator and its double converter.
package sqtri_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FP_W     = 64;
    localparam int unsigned CONV_LAT = 6;
    localparam int unsigned F64_BIAS = 1023;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned MANT_W   = 52;
    localparam int unsigned LZC_W    = 5;

    typedef enum logic [1:0] {
        SRC_SQUARE   = 2'd0,
        SRC_TRIANGLE = 2'd1,
        SRC_EXT      = 2'd2,
        SRC_ZERO     = 2'd3
    } src_sel_e;

    // Leading zeros of a 16-bit word; only used on non-zero inputs.
    function automatic logic [3:0] clz16(input logic [15:0] x);
        logic [3:0] cnt;
        logic       found;
        cnt   = 4'd0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else      cnt   = cnt + 4'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/u32_to_f64_pipe.sv
// Six-stage exact unsigned-32 to IEEE-754 binary64 converter with a
// matching valid pipeline; data registers load only on valid cycles.
module u32_to_f64_pipe
    import sqtri_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din,
    output logic [FP_W-1:0]   dout,
    output logic              out_valid
);

    logic [CONV_LAT-1:0] vld;

    logic              s1_zero;
    logic [DATA_W-1:0] s1_val;
    logic              s2_zero;
    logic [DATA_W-1:0] s2_val;
    logic              s2_lzc_hi;
    logic              s3_zero;
    logic [DATA_W-1:0] s3_val;
    logic [LZC_W-1:0]  s3_lzc;
    logic              s4_zero;
    logic [DATA_W-2:0] s4_frac;
    logic [LZC_W-1:0]  s4_lzc;
    logic [FP_W-1:0]   s5_word;

    logic              upper_zero_c;
    logic [EXP_W-1:0]  exp_c;
    logic [MANT_W-1:0] mant_c;

    always_comb begin
        upper_zero_c = (s1_val[DATA_W-1:16] == 16'd0);
        exp_c        = EXP_W'(F64_BIAS + DATA_W - 1) - EXP_W'(s4_lzc);
        mant_c       = {s4_frac, (MANT_W - DATA_W + 1)'(0)};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld       <= '0;
            s1_zero   <= 1'b0;
            s1_val    <= '0;
            s2_zero   <= 1'b0;
            s2_val    <= '0;
            s2_lzc_hi <= 1'b0;
            s3_zero   <= 1'b0;
            s3_val    <= '0;
            s3_lzc    <= '0;
            s4_zero   <= 1'b0;
            s4_frac   <= '0;
            s4_lzc    <= '0;
            s5_word   <= '0;
            dout      <= '0;
        end else begin
            vld <= {vld[CONV_LAT-2:0], in_valid};
            if (in_valid) begin
                s1_zero <= (din == '0);
                s1_val  <= din;
            end
            // Coarse count: pre-shift by 16 when the upper half is empty.
            if (vld[0]) begin
                s2_zero   <= s1_zero;
                s2_val    <= upper_zero_c ? (s1_val << 16) : s1_val;
                s2_lzc_hi <= upper_zero_c;
            end
            if (vld[1]) begin
                s3_zero <= s2_zero;
                s3_val  <= s2_val;
                s3_lzc  <= {s2_lzc_hi, clz16(s2_val[DATA_W-1:16])};
            end
            // Drop the implicit leading one after normalising.
            if (vld[2]) begin
                s4_zero <= s3_zero;
                s4_frac <= (DATA_W-1)'(s3_val << s3_lzc[3:0]);
                s4_lzc  <= s3_lzc;
            end
            if (vld[3]) begin
                s5_word <= s4_zero ? '0 : {1'b0, exp_c, mant_c};
            end
            if (vld[4]) begin
                dout <= s5_word;
            end
        end
    end

    assign out_valid = vld[CONV_LAT-1];

endmodule

// File: rtl/sqtri_float_gen.sv
// Square/triangle wavetable sample generator feeding a u32->f64 converter.
// Define SQTRI_TRIANGLE_EN to build the triangle table; otherwise sel 1 gives square.
module sqtri_float_gen
    import sqtri_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] dataa,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [FP_W-1:0]   result,
    output logic              result_valid
);

    localparam int unsigned PHASE_W = ADDR_W - 1;

    logic [DATA_W-1:0] square_c;
    logic [DATA_W-1:0] wave1_c;
    logic [DATA_W-1:0] src_c;

    assign square_c = address[ADDR_W-1] ? '0 : '1;

`ifdef SQTRI_TRIANGLE_EN
    localparam int unsigned TRI_SHIFT = DATA_W - PHASE_W;

    logic [PHASE_W-1:0] phase_c;

    // Second half mirrors the first so the ramp falls back to zero.
    assign phase_c = address[ADDR_W-1] ? ~address[PHASE_W-1:0] : address[PHASE_W-1:0];
    assign wave1_c = DATA_W'(phase_c) << TRI_SHIFT;
`else
    logic unused_phase_c;

    assign unused_phase_c = ^address[PHASE_W-1:0];
    assign wave1_c        = square_c;
`endif

    always_comb begin
        src_c = '0;
        case (src_sel_e'(sel))
            SRC_SQUARE:   src_c = square_c;
            SRC_TRIANGLE: src_c = wave1_c;
            SRC_EXT:      src_c = dataa;
            SRC_ZERO:     src_c = '0;
            default:      src_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= in_valid;
            if (in_valid) sample <= src_c;
        end
    end

    u32_to_f64_pipe u_conv (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (sample_valid),
        .din       (sample),
        .dout      (result),
        .out_valid (result_valid)
    );

endmodule

// File: tb/tb_sqtri_float_gen.sv
// Randomised self-checking bench for sqtri_float_gen against an arithmetic
// reference (real-number conversion, per-request history of depth 7).
module tb_sqtri_float_gen;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 7;

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic [AW-1:0] address;
    logic [1:0]    sel;
    logic [31:0]   dataa;
    logic [31:0]   sample;
    logic          sample_valid;
    logic [63:0]   result;
    logic          result_valid;

    int n_checks;
    int n_fail;

    logic        vh [LAT];
    logic [31:0] wh [LAT];
    logic [31:0] exp_sample;
    logic [63:0] exp_result;

    sqtri_float_gen #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .in_valid     (in_valid),
        .address      (address),
        .sel          (sel),
        .dataa        (dataa),
        .sample       (sample),
        .sample_valid (sample_valid),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_source(input logic [1:0] s, input logic [AW-1:0] a,
                                               input logic [31:0] d);
        longint half;
        longint r;
        half = longint'(1) << (AW - 1);
        case (s)
            2'd0: return (longint'(a) < half) ? 32'hFFFF_FFFF : 32'h0;
            2'd1: begin
`ifdef SQTRI_TRIANGLE_EN
                r = (longint'(a) < half) ? longint'(a) : (2 * half - 1 - longint'(a));
                return 32'(r * (longint'(1) << (32 - (AW - 1))));
`else
                r = 0;
                return (longint'(a) < half) ? 32'hFFFF_FFFF : 32'h0;
`endif
            end
            2'd2: return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] ref_f64(input logic [31:0] w);
        real rv;
        rv = real'(longint'({32'h0, w}));
        return $realtobits(rv);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LAT; i++) begin
            vh[i] = 1'b0;
            wh[i] = 32'h0;
        end
        exp_sample = 32'h0;
        exp_result = 64'h0;
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic [AW-1:0] a,
                        input logic [31:0] d);
        in_valid = v;
        sel      = s;
        address  = a;
        dataa    = d;
        @(posedge clk);
        #1;
        if (!nreset) begin
            model_clear();
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                vh[i] = vh[i-1];
                wh[i] = wh[i-1];
            end
            vh[0] = v;
            wh[0] = ref_source(s, a, d);
            if (vh[0]) exp_sample = wh[0];
            if (vh[LAT-1]) exp_result = ref_f64(wh[LAT-1]);
        end
        check("sample_valid", 64'(sample_valid), 64'(vh[0]));
        check("sample", 64'(sample), 64'(exp_sample));
        check("result_valid", 64'(result_valid), 64'(vh[LAT-1]));
        check("result", result, exp_result);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nreset   = 1'b0;
        in_valid = 1'b0;
        sel      = 2'd0;
        address  = '0;
        dataa    = 32'h0;
        model_clear();

        idle(3);
        check("reset_sample", 64'(sample), 64'h0);
        check("reset_result_valid", 64'(result_valid), 64'h0);
        nreset = 1'b1;

        // Square at address 0: 1-cycle sample, 7-cycle result.
        step(1'b1, 2'd0, 10'd0, 32'h0);
        check("sq0_sample", 64'(sample), 64'hFFFF_FFFF);
        idle(5);
        check("sq0_result_early", 64'(result_valid), 64'h0);
        idle(1);
        check("sq0_result_valid", 64'(result_valid), 64'h1);
        check("sq0_result", result, 64'h41EF_FFFF_FFE0_0000);

        step(1'b1, 2'd0, 10'd512, 32'h0);
        check("sq512_sample", 64'(sample), 64'h0);
        idle(6);
        check("sq512_result", result, 64'h0);

        // Triangle corner addresses, back to back.
        step(1'b1, 2'd1, 10'd0, 32'h0);
        step(1'b1, 2'd1, 10'd1, 32'h0);
`ifdef SQTRI_TRIANGLE_EN
        check("tri1_sample", 64'(sample), 64'h0080_0000);
`endif
        step(1'b1, 2'd1, 10'd511, 32'h0);
        step(1'b1, 2'd1, 10'd512, 32'h0);
        step(1'b1, 2'd1, 10'd1023, 32'h0);
        idle(3);
`ifdef SQTRI_TRIANGLE_EN
        check("tri1_result", result, 64'h4160_0000_0000_0000);
`endif
        idle(4);

        // Without the triangle table sel 1 falls back to the square wave.
        step(1'b1, 2'd1, 10'd0, 32'h0);
`ifndef SQTRI_TRIANGLE_EN
        check("sel1_square", 64'(sample), 64'hFFFF_FFFF);
`endif
        idle(7);

        // External words back to back.
        step(1'b1, 2'd2, '0, 32'h1);
        step(1'b1, 2'd2, '0, 32'h8000_0000);
        step(1'b1, 2'd2, '0, 32'h3);
        idle(4);
        check("ext_1", result, 64'h3FF0_0000_0000_0000);
        idle(1);
        check("ext_8000", result, 64'h41E0_0000_0000_0000);
        idle(1);
        check("ext_3", result, 64'h4008_0000_0000_0000);
        idle(2);

        // Reset pulse with four requests in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 2'd2, '0, 32'h1234_5678 + 32'(i));
        #2;
        nreset = 1'b0;
        #1;
        check("rst_sample", 64'(sample), 64'h0);
        check("rst_sample_valid", 64'(sample_valid), 64'h0);
        check("rst_result", result, 64'h0);
        check("rst_result_valid", 64'(result_valid), 64'h0);
        model_clear();
        idle(2);
        #2;
        nreset = 1'b1;
        idle(9);

        // Randomised streaming traffic.
        for (int i = 0; i < 600; i++) begin
            logic        v;
            logic [1:0]  s;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = $urandom >> $urandom_range(0, 31);
            step(v, s, AW'($urandom), d);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
